// File: rtl/lc3b_icache_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lc3b_icache_pkg
// Purpose  : Shared line/address types and FSM state encoding for the
//            LC-3b direct-mapped instruction/line cache.
// Revision : 1.0 - initial release
// ============================================================================
package lc3b_icache_pkg;

    localparam int c_lc3b_line_width = 128;
    localparam int c_lc3b_addr_width = 12;
    localparam int c_lc3b_sel_width  = c_lc3b_line_width / 8;

    typedef logic [c_lc3b_line_width-1:0] lc3b_line;
    typedef logic [c_lc3b_addr_width-1:0] lc3b_line_addr;
    typedef logic [c_lc3b_sel_width-1:0]  lc3b_line_sel;

    // Explicit 2-bit encoding keeps the state register width fixed
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } icache_state_t;

endpackage
`default_nettype wire

// File: rtl/lc3b_icache_if.sv
`default_nettype none
// ============================================================================
// Module   : lc3b_icache_if
// Purpose  : Wishbone-style line bus (128-bit lines) used on both the CPU
//            side (cache is slave) and the memory side (cache is master).
// Revision : 1.0 - initial release
// ============================================================================
interface lc3b_icache_if
    import lc3b_icache_pkg::*;
#(
    parameter int ADDR_WIDTH = c_lc3b_addr_width,
    parameter int LINE_WIDTH = c_lc3b_line_width
);
    logic                    cyc;
    logic                    stb;
    logic                    we;
    logic [ADDR_WIDTH-1:0]   adr;
    logic [LINE_WIDTH/8-1:0] sel;
    logic [LINE_WIDTH-1:0]   dat_m;
    logic [LINE_WIDTH-1:0]   dat_s;
    logic                    ack;

    modport master (
        output cyc, stb, we, adr, sel, dat_m,
        input  dat_s, ack
    );

    modport slave (
        input  cyc, stb, we, adr, sel, dat_m,
        output dat_s, ack
    );
endinterface
`default_nettype wire

// File: rtl/lc3b_icache_array.sv
`default_nettype none
// ============================================================================
// Module   : lc3b_icache_array
// Purpose  : Valid/tag/data storage for the direct-mapped cache. Combinational
//            read by index, synchronous line write, clear-all and single-line
//            invalidate. Only the valid bits are cleared; tag/data are not.
// Revision : 1.0 - initial release
// ============================================================================
module lc3b_icache_array #(
    parameter int IDX_WIDTH  = 3,
    parameter int TAG_WIDTH  = 9,
    parameter int LINE_WIDTH = 128
) (
    input  wire logic                  clk,
    input  wire logic                  i_clear,
    input  wire logic                  i_inv,
    input  wire logic [IDX_WIDTH-1:0]  i_inv_idx,
    input  wire logic                  i_load,
    input  wire logic [IDX_WIDTH-1:0]  i_wr_idx,
    input  wire logic [TAG_WIDTH-1:0]  i_wr_tag,
    input  wire logic [LINE_WIDTH-1:0] i_wr_line,
    input  wire logic [IDX_WIDTH-1:0]  i_rd_idx,
    output logic                       o_rd_valid,
    output logic [TAG_WIDTH-1:0]       o_rd_tag,
    output logic [LINE_WIDTH-1:0]      o_rd_line
);
    localparam int c_num_lines = 1 << IDX_WIDTH;

    logic [c_num_lines-1:0] r_valid;
    logic [TAG_WIDTH-1:0]   r_tag  [c_num_lines];
    logic [LINE_WIDTH-1:0]  r_data [c_num_lines];

    // Valid bits: clear-all wins over install and invalidate
    always_ff @(posedge clk) begin
        if (i_clear) begin
            r_valid <= '0;
        end else begin
            if (i_load) r_valid[i_wr_idx]  <= 1'b1;
            if (i_inv)  r_valid[i_inv_idx] <= 1'b0;
        end
    end

    // Tag and data storage, written only when a fill installs a line
    always_ff @(posedge clk) begin
        if (i_load) begin
            r_tag[i_wr_idx]  <= i_wr_tag;
            r_data[i_wr_idx] <= i_wr_line;
        end
    end

    assign o_rd_valid = r_valid[i_rd_idx];
    assign o_rd_tag   = r_tag[i_rd_idx];
    assign o_rd_line  = r_data[i_rd_idx];
endmodule
`default_nettype wire

// File: rtl/lc3b_icache.sv
`default_nettype none
// ============================================================================
// Module   : lc3b_icache
// Purpose  : Direct-mapped read-allocate line cache. Read hits answer from the
//            array with one cycle latency, read misses fill a whole line from
//            memory, writes bypass to memory and invalidate a matching line.
// Revision : 1.0 - initial release
// ============================================================================
module lc3b_icache
    import lc3b_icache_pkg::*;
#(
    parameter int NUM_LINES  = 8,
    parameter int ADDR_WIDTH = c_lc3b_addr_width,
    parameter int LINE_WIDTH = c_lc3b_line_width
) (
    input  wire logic     clk,
    input  wire logic     rst,
    lc3b_icache_if.slave  cpu,
    lc3b_icache_if.master mem
);
    localparam int c_idx       = $clog2(NUM_LINES);
    localparam int c_tag_width = ADDR_WIDTH - c_idx;
    localparam int c_sel_width = LINE_WIDTH / 8;

    icache_state_t r_state;
    icache_state_t w_state_next;

    logic                    w_req;
    logic                    w_hit;
    logic [c_idx-1:0]        w_cpu_idx;
    logic [c_tag_width-1:0]  w_cpu_tag;
    logic                    w_rd_valid;
    logic [c_tag_width-1:0]  w_rd_tag;
    logic [LINE_WIDTH-1:0]   w_rd_line;
    logic                    w_load;
    logic                    w_inv;

    logic                    r_ack,       w_ack;
    logic [LINE_WIDTH-1:0]   r_dat_s,     w_dat_s;
    logic                    r_mem_cyc,   w_mem_cyc;
    logic                    r_mem_we,    w_mem_we;
    logic [ADDR_WIDTH-1:0]   r_mem_adr,   w_mem_adr;
    logic [c_sel_width-1:0]  r_mem_sel,   w_mem_sel;
    logic [LINE_WIDTH-1:0]   r_mem_dat_m, w_mem_dat_m;

    assign w_req     = cpu.cyc & cpu.stb;
    assign w_cpu_idx = cpu.adr[c_idx-1:0];
    assign w_cpu_tag = cpu.adr[ADDR_WIDTH-1:c_idx];
    assign w_hit     = w_rd_valid && (w_rd_tag == w_cpu_tag);

    // The memory address register holds the accepted line address for the
    // whole fill, so it also supplies the install index and tag.
    lc3b_icache_array #(
        .IDX_WIDTH  (c_idx),
        .TAG_WIDTH  (c_tag_width),
        .LINE_WIDTH (LINE_WIDTH)
    ) u_array (
        .clk        (clk),
        .i_clear    (rst),
        .i_inv      (w_inv),
        .i_inv_idx  (w_cpu_idx),
        .i_load     (w_load),
        .i_wr_idx   (r_mem_adr[c_idx-1:0]),
        .i_wr_tag   (r_mem_adr[ADDR_WIDTH-1:c_idx]),
        .i_wr_line  (mem.dat_s),
        .i_rd_idx   (w_cpu_idx),
        .o_rd_valid (w_rd_valid),
        .o_rd_tag   (w_rd_tag),
        .o_rd_line  (w_rd_line)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state logic; RESP always returns to IDLE so requests are >= 2 apart
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    if (cpu.we)     w_state_next = WRITE;
                    else if (w_hit) w_state_next = RESP;
                    else            w_state_next = FILL;
                end
            end
            FILL:    if (mem.ack) w_state_next = RESP;
            WRITE:   if (mem.ack) w_state_next = RESP;
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Next values of the registered bus outputs and array strobes
    always_comb begin
        w_ack       = 1'b0;
        w_dat_s     = r_dat_s;
        w_mem_cyc   = r_mem_cyc;
        w_mem_we    = r_mem_we;
        w_mem_adr   = r_mem_adr;
        w_mem_sel   = r_mem_sel;
        w_mem_dat_m = r_mem_dat_m;
        w_load      = 1'b0;
        w_inv       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    if (cpu.we) begin
                        w_mem_cyc   = 1'b1;
                        w_mem_we    = 1'b1;
                        w_mem_adr   = cpu.adr;
                        w_mem_sel   = cpu.sel;
                        w_mem_dat_m = cpu.dat_m;
                        w_inv       = w_hit;
                    end else if (w_hit) begin
                        w_dat_s = w_rd_line;
                        w_ack   = 1'b1;
                    end else begin
                        w_mem_cyc = 1'b1;
                        w_mem_we  = 1'b0;
                        w_mem_adr = cpu.adr;
                        w_mem_sel = '1;
                    end
                end
            end
            FILL: begin
                // The line is installed even if the CPU abandoned the cycle
                if (mem.ack) begin
                    w_load    = 1'b1;
                    w_dat_s   = mem.dat_s;
                    w_mem_cyc = 1'b0;
                    w_ack     = cpu.cyc;
                end
            end
            WRITE: begin
                if (mem.ack) begin
                    w_dat_s   = '0;
                    w_mem_cyc = 1'b0;
                    w_mem_we  = 1'b0;
                    w_ack     = cpu.cyc;
                end
            end
            default: ;
        endcase
    end

    // Output registers; reset kills any in-flight memory cycle and response
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ack       <= 1'b0;
            r_dat_s     <= '0;
            r_mem_cyc   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_adr   <= '0;
            r_mem_sel   <= '0;
            r_mem_dat_m <= '0;
        end else begin
            r_ack       <= w_ack;
            r_dat_s     <= w_dat_s;
            r_mem_cyc   <= w_mem_cyc;
            r_mem_we    <= w_mem_we;
            r_mem_adr   <= w_mem_adr;
            r_mem_sel   <= w_mem_sel;
            r_mem_dat_m <= w_mem_dat_m;
        end
    end

    assign cpu.ack   = r_ack;
    assign cpu.dat_s = r_dat_s;
    assign mem.cyc   = r_mem_cyc;
    assign mem.stb   = r_mem_cyc;
    assign mem.we    = r_mem_we;
    assign mem.adr   = r_mem_adr;
    assign mem.sel   = r_mem_sel;
    assign mem.dat_m = r_mem_dat_m;
endmodule
`default_nettype wire

// File: tb/tb_lc3b_icache.sv
`default_nettype none
// ============================================================================
// Module   : tb_lc3b_icache
// Purpose  : Self-checking bench for lc3b_icache: table of read/write
//            transactions plus reset-mid-fill, held-strobe, aborted-fill and
//            stray-ack sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lc3b_icache;
    import lc3b_icache_pkg::*;

    typedef struct {
        logic          we;
        lc3b_line_addr adr;
        lc3b_line_sel  sel;
        lc3b_line      dat;
        logic          miss;
        lc3b_line      rdata;
        lc3b_line      exp;
    } vec_t;

    localparam lc3b_line c_a = 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A501;
    localparam lc3b_line c_b = 128'h0BADF00D_DEADBEEF_CAFEF00D_00000018;
    localparam lc3b_line c_d = 128'h12345678_9ABCDEF0_0FEDCBA9_87654321;
    localparam lc3b_line c_e = 128'h11111111_22222222_33333333_44444411;
    localparam lc3b_line c_f = 128'h77777777_66666666_55555555_44444417;
    localparam lc3b_line c_g = 128'hFFFF0000_FFFF0000_FFFF0000_FFFF0000;
    localparam lc3b_line c_h = 128'h30303030_30303030_30303030_30303030;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    lc3b_icache_if cpu_bus ();
    lc3b_icache_if mem_bus ();

    lc3b_icache dut (
        .clk (clk),
        .rst (rst),
        .cpu (cpu_bus),
        .mem (mem_bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached (got timeout, required completion)");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // One CPU transaction; memory answers after two wait cycles on a miss
    task automatic run_vec(input vec_t v, input string tag);
        @(negedge clk);
        cpu_bus.cyc   = 1'b1;
        cpu_bus.stb   = 1'b1;
        cpu_bus.we    = v.we;
        cpu_bus.adr   = v.adr;
        cpu_bus.sel   = v.sel;
        cpu_bus.dat_m = v.dat;
        @(posedge clk); #1;
        if (v.miss) begin
            chk({tag, "_mem_cyc"}, mem_bus.cyc, 1);
            chk({tag, "_mem_stb"}, mem_bus.stb, 1);
            chk({tag, "_mem_we"},  mem_bus.we, v.we);
            chk({tag, "_mem_adr"}, mem_bus.adr, v.adr);
            chk({tag, "_mem_sel"}, mem_bus.sel, v.we ? v.sel : 16'hFFFF);
            if (v.we) chk({tag, "_mem_dat_m"}, mem_bus.dat_m, v.dat);
            chk({tag, "_early_ack"}, cpu_bus.ack, 0);
            repeat (2) begin
                @(posedge clk); #1;
                chk({tag, "_hold_cyc"}, mem_bus.cyc, 1);
                chk({tag, "_wait_ack"}, cpu_bus.ack, 0);
            end
            @(negedge clk);
            mem_bus.ack   = 1'b1;
            mem_bus.dat_s = v.rdata;
            @(posedge clk); #1;
            mem_bus.ack = 1'b0;
        end
        chk({tag, "_ack"},       cpu_bus.ack, 1);
        chk({tag, "_dat_s"},     cpu_bus.dat_s, v.exp);
        chk({tag, "_mem_idle"},  mem_bus.cyc, 0);
        chk({tag, "_mem_we_lo"}, mem_bus.we, 0);
        @(negedge clk);
        cpu_bus.cyc = 1'b0;
        cpu_bus.stb = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_ack_pulse"}, cpu_bus.ack, 0);
    endtask

    vec_t vecs [15];
    vec_t v;

    initial begin
        checks = 0;
        errors = 0;

        vecs[0]  = '{1'b0, 12'h010, 16'h0000, '0,  1'b1, c_a, c_a}; // cold miss
        vecs[1]  = '{1'b0, 12'h010, 16'h0000, '0,  1'b0, '0,  c_a}; // hit
        vecs[2]  = '{1'b0, 12'h018, 16'h0000, '0,  1'b1, c_b, c_b}; // conflict
        vecs[3]  = '{1'b0, 12'h010, 16'h0000, '0,  1'b1, c_a, c_a}; // evicted
        vecs[4]  = '{1'b0, 12'h018, 16'h0000, '0,  1'b1, c_b, c_b};
        vecs[5]  = '{1'b1, 12'h018, 16'h00FF, c_d, 1'b1, '0,  '0 }; // write hit
        vecs[6]  = '{1'b0, 12'h018, 16'h0000, '0,  1'b1, c_b, c_b}; // invalidated
        vecs[7]  = '{1'b0, 12'h011, 16'h0000, '0,  1'b1, c_e, c_e};
        vecs[8]  = '{1'b1, 12'h019, 16'hFFFF, c_g, 1'b1, '0,  '0 }; // tag differs
        vecs[9]  = '{1'b0, 12'h011, 16'h0000, '0,  1'b0, '0,  c_e}; // still hit
        vecs[10] = '{1'b1, 12'h011, 16'hF0F0, c_g, 1'b1, '0,  '0 }; // write hit
        vecs[11] = '{1'b0, 12'h011, 16'h0000, '0,  1'b1, c_e, c_e};
        vecs[12] = '{1'b0, 12'h018, 16'h0000, '0,  1'b0, '0,  c_b};
        vecs[13] = '{1'b0, 12'h017, 16'h0000, '0,  1'b1, c_f, c_f};
        vecs[14] = '{1'b0, 12'h017, 16'h0000, '0,  1'b0, '0,  c_f};

        cpu_bus.cyc   = 1'b0;
        cpu_bus.stb   = 1'b0;
        cpu_bus.we    = 1'b0;
        cpu_bus.adr   = '0;
        cpu_bus.sel   = '0;
        cpu_bus.dat_m = '0;
        mem_bus.ack   = 1'b0;
        mem_bus.dat_s = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack",       cpu_bus.ack, 0);
        chk("rst_dat_s",     cpu_bus.dat_s, 0);
        chk("rst_mem_cyc",   mem_bus.cyc, 0);
        chk("rst_mem_stb",   mem_bus.stb, 0);
        chk("rst_mem_we",    mem_bus.we, 0);
        chk("rst_mem_adr",   mem_bus.adr, 0);
        chk("rst_mem_sel",   mem_bus.sel, 0);
        chk("rst_mem_dat_m", mem_bus.dat_m, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
        end

        // Reset while a fill is outstanding; the late ack must be ignored
        @(negedge clk);
        cpu_bus.cyc = 1'b1;
        cpu_bus.stb = 1'b1;
        cpu_bus.we  = 1'b0;
        cpu_bus.adr = 12'h020;
        @(posedge clk); #1;
        chk("rf_mem_cyc", mem_bus.cyc, 1);
        chk("rf_mem_adr", mem_bus.adr, 12'h020);
        @(negedge clk);
        rst = 1'b1;
        cpu_bus.cyc = 1'b0;
        cpu_bus.stb = 1'b0;
        @(posedge clk); #1;
        chk("rf_kill_cyc", mem_bus.cyc, 0);
        chk("rf_kill_ack", cpu_bus.ack, 0);
        @(negedge clk);
        rst = 1'b0;
        mem_bus.ack   = 1'b1;
        mem_bus.dat_s = c_h;
        @(posedge clk); #1;
        mem_bus.ack = 1'b0;
        chk("rf_late_ack", cpu_bus.ack, 0);
        chk("rf_late_cyc", mem_bus.cyc, 0);
        @(posedge clk); #1;
        chk("rf_late_ack2", cpu_bus.ack, 0);
        // Previously valid lines at indices 7 and 0 must now miss
        v = '{1'b0, 12'h017, 16'h0000, '0, 1'b1, c_f, c_f};
        run_vec(v, "rf_017");
        v = '{1'b0, 12'h010, 16'h0000, '0, 1'b1, c_a, c_a};
        run_vec(v, "rf_010");

        // Strobe held on a hit: ack on every second cycle only
        @(negedge clk);
        cpu_bus.cyc = 1'b1;
        cpu_bus.stb = 1'b1;
        cpu_bus.we  = 1'b0;
        cpu_bus.adr = 12'h010;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            chk($sformatf("held_ack%0d", k), cpu_bus.ack, (k % 2 == 0) ? 128'd1 : 128'd0);
            chk($sformatf("held_cyc%0d", k), mem_bus.cyc, 0);
            if (k % 2 == 0) chk($sformatf("held_dat%0d", k), cpu_bus.dat_s, c_a);
        end
        @(negedge clk);
        cpu_bus.cyc = 1'b0;
        cpu_bus.stb = 1'b0;
        @(posedge clk); #1;
        chk("held_end_ack", cpu_bus.ack, 0);

        // CPU abandons a fill: no ack, but the line is still installed
        @(negedge clk);
        cpu_bus.cyc = 1'b1;
        cpu_bus.stb = 1'b1;
        cpu_bus.adr = 12'h030;
        @(posedge clk); #1;
        chk("ab_mem_cyc", mem_bus.cyc, 1);
        chk("ab_mem_adr", mem_bus.adr, 12'h030);
        @(negedge clk);
        cpu_bus.cyc   = 1'b0;
        cpu_bus.stb   = 1'b0;
        mem_bus.ack   = 1'b1;
        mem_bus.dat_s = c_h;
        @(posedge clk); #1;
        mem_bus.ack = 1'b0;
        chk("ab_ack",     cpu_bus.ack, 0);
        chk("ab_mem_end", mem_bus.cyc, 0);
        @(posedge clk); #1;
        chk("ab_ack2", cpu_bus.ack, 0);
        v = '{1'b0, 12'h030, 16'h0000, '0, 1'b0, '0, c_h};
        run_vec(v, "ab_hit");

        // Stray memory ack while idle changes nothing
        @(negedge clk);
        mem_bus.ack   = 1'b1;
        mem_bus.dat_s = c_g;
        @(posedge clk); #1;
        mem_bus.ack = 1'b0;
        chk("stray_ack", cpu_bus.ack, 0);
        chk("stray_cyc", mem_bus.cyc, 0);
        chk("stray_dat", cpu_bus.dat_s, c_h);
        run_vec(v, "stray_hit");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
